// File: rtl/spi_master_bram_client.sv
// SPI Mode 0 master that builds 0xDC-headed read/write frames for the SPI-to-BRAM
// slave port and returns the 0xBC-headed read reply on a response port.
module spi_master_bram_client #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 13,
   parameter int CLK_DIV    = 8,
   parameter int CS_GAP     = 16,
   parameter int TURNAROUND = 16
) (
   input  logic                  sys_clk_in,
   input  logic                  sys_rst_in,
   input  logic                  cmd_valid_in,
   output logic                  cmd_ready_out,
   input  logic                  cmd_write_in,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_in,
   output logic                  rsp_valid_out,
   output logic [DATA_WIDTH-1:0] rsp_rdata_out,
   output logic                  rsp_err_out,
   output logic                  busy_out,
   output logic                  sclk_out,
   output logic                  mosi_out,
   output logic                  cs_out,
   input  logic                  miso_in
);
   localparam logic [7:0] HDR_CMD = 8'hDC;
   localparam logic [7:0] OP_WR   = 8'hAB;
   localparam logic [7:0] OP_RD   = 8'hCB;
   localparam logic [7:0] HDR_RSP = 8'hBC;

   localparam int TX_W    = 16 + ADDR_WIDTH + DATA_WIDTH;
   localparam int BIT_W   = $clog2(TX_W + 1);
   localparam int CNT_MAX = (CLK_DIV > CS_GAP)
                            ? ((CLK_DIV > TURNAROUND) ? CLK_DIV : TURNAROUND)
                            : ((CS_GAP > TURNAROUND) ? CS_GAP : TURNAROUND);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DIV_TC  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] TA_TC   = CNT_W'(TURNAROUND - 1);
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(CS_GAP - 1);
   localparam logic [BIT_W-1:0] LAST_WR = BIT_W'(TX_W - 1);
   localparam logic [BIT_W-1:0] LAST_RD = BIT_W'(TX_W - DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] LAST_RX = BIT_W'(16);

   typedef enum logic [2:0] {
      S_IDLE, S_CS_SETUP, S_SHIFT_TX, S_COMMIT,
      S_TURNAROUND, S_SHIFT_RX, S_CS_HOLD, S_CS_GAP
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [TX_W-1:0]       sr_q, sr_d;
   logic [15:0]           rx_q, rx_d;
   logic                  wr_q, wr_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_q, cs_d;
   logic                  mosi_q, mosi_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  busy_q, busy_d;
   logic                  miso_meta_q, miso_sync_q;
   logic                  div_tc;

   assign div_tc = (cnt_q == DIV_TC);

   always_ff @(posedge sys_clk_in or posedge sys_rst_in) begin
      if (sys_rst_in) begin
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         miso_meta_q <= miso_in;
         miso_sync_q <= miso_meta_q;
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_d       = bit_q;
      sr_d        = sr_q;
      rx_d        = rx_q;
      wr_d        = wr_q;
      sclk_d      = sclk_q;
      cs_d        = cs_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (cmd_valid_in) begin
               // Reads zero the data field so MOSI falls to 0 once the frame is out.
               state_d = S_CS_SETUP;
               bit_d   = '0;
               wr_d    = cmd_write_in;
               sr_d    = {HDR_CMD, cmd_write_in ? OP_WR : OP_RD, cmd_addr_in,
                          cmd_write_in ? cmd_wdata_in : {DATA_WIDTH{1'b0}}};
               cs_d    = 1'b0;
               mosi_d  = sr_d[TX_W-1];
            end
         end
         S_CS_SETUP: begin
            if (div_tc) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               state_d = S_SHIFT_TX;
            end
         end
         S_SHIFT_TX: begin
            if (div_tc) begin
               cnt_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  sr_d   = sr_q << 1;
                  mosi_d = sr_q[TX_W-2];
               end else if (bit_q == (wr_q ? LAST_WR : LAST_RD)) begin
                  bit_d = '0;
                  if (wr_q) begin
                     state_d = S_COMMIT;
                     sclk_d  = 1'b1;
                  end else begin
                     state_d = S_TURNAROUND;
                  end
               end else begin
                  bit_d  = bit_q + 1'b1;
                  sclk_d = 1'b1;
               end
            end
         end
         S_COMMIT: begin
            if (div_tc) begin
               cnt_d = '0;
               if (sclk_q) sclk_d = 1'b0;
               else        state_d = S_CS_HOLD;
            end
         end
         S_TURNAROUND: begin
            // This rising edge is the dummy pulse; nothing is sampled on it.
            if (cnt_q == TA_TC) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               state_d = S_SHIFT_RX;
            end
         end
         S_SHIFT_RX: begin
            if (div_tc) begin
               cnt_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
               end else if (bit_q == LAST_RX) begin
                  state_d = S_CS_HOLD;
               end else begin
                  bit_d  = bit_q + 1'b1;
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[14:0], miso_sync_q};
               end
            end
         end
         S_CS_HOLD: begin
            if (div_tc) begin
               cnt_d   = '0;
               cs_d    = 1'b1;
               state_d = S_CS_GAP;
               if (!wr_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = rx_q[DATA_WIDTH-1:0];
                  rsp_err_d   = (rx_q[15:8] != HDR_RSP);
               end
            end
         end
         S_CS_GAP: begin
            if (cnt_q == GAP_TC) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge sys_clk_in or posedge sys_rst_in) begin
      if (sys_rst_in) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         sr_q        <= '0;
         rx_q        <= '0;
         wr_q        <= 1'b0;
         sclk_q      <= 1'b0;
         cs_q        <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         sr_q        <= sr_d;
         rx_q        <= rx_d;
         wr_q        <= wr_d;
         sclk_q      <= sclk_d;
         cs_q        <= cs_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_ready_out = (state_q == S_IDLE) & ~sys_rst_in;
   assign rsp_valid_out = rsp_valid_q;
   assign rsp_rdata_out = rsp_rdata_q;
   assign rsp_err_out   = rsp_err_q;
   assign busy_out      = busy_q;
   assign sclk_out      = sclk_q;
   assign mosi_out      = mosi_q;
   assign cs_out        = cs_q;

endmodule

// File: tb/tb_spi_master_bram_client.sv
// Directed bench for spi_master_bram_client with a behavioural SPI-to-BRAM slave
// and a frame monitor that measures CS, SCLK and MOSI timing.
module tb_spi_master_bram_client;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [12:0] cmd_addr = '0;
   logic [7:0]  cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, rsp_err, busy, sclk, mosi, cs, miso;
   logic [7:0]  rsp_rdata;
   logic        slave_en = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   spi_master_bram_client dut (
      .sys_clk_in   (clk),
      .sys_rst_in   (rst),
      .cmd_valid_in (cmd_valid),
      .cmd_ready_out(cmd_ready),
      .cmd_write_in (cmd_write),
      .cmd_addr_in  (cmd_addr),
      .cmd_wdata_in (cmd_wdata),
      .rsp_valid_out(rsp_valid),
      .rsp_rdata_out(rsp_rdata),
      .rsp_err_out  (rsp_err),
      .busy_out     (busy),
      .sclk_out     (sclk),
      .mosi_out     (mosi),
      .cs_out       (cs),
      .miso_in      (miso)
   );

   // Behavioural slave: decodes frames, commits writes on rising edge 38,
   // and shifts out {BC, mem[addr]} after the dummy edge of a read.
   logic [7:0]  mem [0:8191];
   logic [63:0] cap = '0, last_cap = '0;
   logic [15:0] reply = '0;
   int          rises = 0;
   logic        is_rd = 1'b0, miso_r = 1'b0, s_sclk_p = 1'b0, s_cs_p = 1'b1;

   assign miso = slave_en ? miso_r : 1'b0;

   always @(posedge clk) begin
      s_sclk_p <= sclk;
      s_cs_p   <= cs;
      if (rst) begin
         mem[13'h1FFF] <= 8'h3C;
         mem[13'h0055] <= 8'h77;
         mem[13'h0AAA] <= 8'h00;
      end
      if (cs) begin
         if (!s_cs_p) last_cap <= cap;
         cap    <= '0;
         rises  <= 0;
         is_rd  <= 1'b0;
         miso_r <= 1'b0;
      end else if (sclk && !s_sclk_p) begin
         rises <= rises + 1;
         cap   <= {cap[62:0], mosi};
         if (rises == 37 && !is_rd && cap[36:29] == 8'hDC && cap[28:21] == 8'hAB)
            mem[cap[20:8]] <= cap[7:0];
         if (rises == 29 && cap[28:21] == 8'hDC && cap[20:13] == 8'hCB) begin
            reply <= {8'hBC, mem[cap[12:0]]};
            is_rd <= 1'b1;
         end
      end else if (!sclk && s_sclk_p && is_rd) begin
         miso_r <= reply[15];
         reply  <= {reply[14:0], 1'b0};
      end
   end

   // Frame monitor: values seen at a clock edge are those of the preceding cycle.
   int   cs_low_n = 0, cs_high_n = 0, last_cs_low = 0, last_cs_high = 0;
   int   rise_n = 0, last_rise = 0, rsp_n = 0, ready_n = 0, mosi_bad = 0;
   logic cs_m = 1'b1, sclk_m = 1'b0, mosi_m = 1'b0;

   always @(posedge clk) begin
      cs_m   <= cs;
      sclk_m <= sclk;
      mosi_m <= mosi;
      if (!cs) begin
         if (cs_m) begin
            last_cs_high <= cs_high_n;
            cs_low_n     <= 1;
            rise_n       <= 0;
         end else begin
            cs_low_n <= cs_low_n + 1;
            if (sclk && !sclk_m) rise_n <= rise_n + 1;
         end
      end else if (!cs_m) begin
         last_cs_low <= cs_low_n;
         last_rise   <= rise_n;
         cs_high_n   <= 1;
      end else begin
         cs_high_n <= cs_high_n + 1;
      end
      if (sclk && mosi != mosi_m) mosi_bad <= mosi_bad + 1;
      if (rsp_valid) rsp_n <= rsp_n + 1;
      if (cmd_ready) ready_n <= ready_n + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic issue(input logic wr, input logic [12:0] addr, input logic [7:0] data);
      @(negedge clk);
      check("ready_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("cs_fall_after_accept", cs, 1'b0);
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy && cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_done"}, ok, 1'b1);
   endtask

   task automatic wait_cs(input logic level, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (cs == level) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_cs_wait"}, ok, 1'b1);
   endtask

   task automatic wait_rises(input int n, output bit ok);
      int   seen;
      logic prev;
      seen = 0;
      prev = sclk;
      ok   = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (sclk && !prev) seen++;
         prev = sclk;
         if (seen == n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int r0, r1;
      rst = 1'b1;
      #1;
      check("rst_sclk",      sclk,      1'b0);
      check("rst_cs",        cs,        1'b1);
      check("rst_mosi",      mosi,      1'b0);
      check("rst_ready",     cmd_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rdata",     rsp_rdata, 8'h00);
      check("rst_err",       rsp_err,   1'b0);
      check("rst_busy",      busy,      1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", cmd_ready, 1'b1);

      // Write 0xA5 to 0x0155
      r0 = rsp_n;
      issue(1'b1, 13'h0155, 8'hA5);
      wait_done("wr1");
      check("wr1_cs_low", last_cs_low, 624);
      check("wr1_rises",  last_rise,   38);
      check("wr1_mosi",   last_cap[37:0], {8'hDC, 8'hAB, 13'h0155, 8'hA5, 1'b0});
      check("wr1_mem",    mem[13'h0155], 8'hA5);
      check("wr1_no_rsp", rsp_n - r0, 0);

      // Read 0x1FFF, slave replies BC 3C
      r0 = rsp_n;
      issue(1'b0, 13'h1FFF, 8'h00);
      wait_done("rd1");
      check("rd1_rsp_pulses", rsp_n - r0, 1);
      check("rd1_rdata",  rsp_rdata, 8'h3C);
      check("rd1_err",    rsp_err,   1'b0);
      check("rd1_cs_low", last_cs_low, 768);
      check("rd1_rises",  last_rise,   46);
      check("rd1_mosi",   last_cap[45:0], {8'hDC, 8'hCB, 13'h1FFF, 17'h0});

      // Read with no slave driving MISO
      slave_en = 1'b0;
      r0 = rsp_n;
      issue(1'b0, 13'h0001, 8'h00);
      wait_done("rd0");
      check("rd0_rsp_pulses", rsp_n - r0, 1);
      check("rd0_rdata", rsp_rdata, 8'h00);
      check("rd0_err",   rsp_err,   1'b1);
      slave_en = 1'b1;

      // Loopback: write 5A to 0x0AAA then read it back
      issue(1'b1, 13'h0AAA, 8'h5A);
      wait_done("lb_wr");
      issue(1'b0, 13'h0AAA, 8'h00);
      wait_done("lb_rd");
      check("lb_rdata", rsp_rdata, 8'h5A);
      check("lb_err",   rsp_err,   1'b0);

      // Reset on the 20th rising SCLK edge of a write
      issue(1'b1, 13'h0055, 8'hEE);
      wait_rises(20, ok);
      check("mid_rst_reached", ok, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_cs",    cs,        1'b1);
      check("mid_rst_sclk",  sclk,      1'b0);
      check("mid_rst_mosi",  mosi,      1'b0);
      check("mid_rst_busy",  busy,      1'b0);
      check("mid_rst_ready", cmd_ready, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_ready_after", cmd_ready, 1'b1);
      issue(1'b0, 13'h0055, 8'h00);
      wait_done("post_rst_rd");
      check("post_rst_rdata", rsp_rdata, 8'h77);
      check("post_rst_err",   rsp_err,   1'b0);

      // cmd_valid held high across two writes
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 13'h0100;
      cmd_wdata = 8'h11;
      wait_cs(1'b0, "b2b_f1");
      r0 = ready_n;
      wait_cs(1'b1, "b2b_f1_end");
      wait_cs(1'b0, "b2b_f2");
      r1 = ready_n;
      cmd_valid = 1'b0;
      wait_done("b2b");
      check("b2b_cs_gap",      last_cs_high, 17);
      check("b2b_ready_once",  r1 - r0, 1);
      check("b2b_mem",         mem[13'h0100], 8'h11);

      check("mosi_stable_high", mosi_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
